board_ctl: RTL and testbench

- Playfield owner for the Tetris game; the consumer side of the falling-block controller's lock/collision interface.
- Holds the occupancy grid and reports `collision` for the active piece's four squares.
- On `lock_en`, writes the piece into the grid, then clears full rows and counts them.
- Serves a row read port to the VGA renderer.

---
 rtl/tetris_pkg.sv | 37 +++
 rtl/collision_chk.sv | 22 ++
 rtl/board_ctl.sv | 134 +++++++++++++
 tb/tb_board_ctl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: playfield geometry, board_ctl state codes and piece codes.
package tetris_pkg;

  localparam int COLS  = 10;
  localparam int ROWS  = 20;
  localparam int COL_W = 4;
  localparam int ROW_W = 5;
  localparam int LINES_W = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    WRITE = ST_WRITE,
    SCAN  = ST_SCAN,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } board_state_e;

  localparam logic [2:0] I_BLOCK = 3'd0;
  localparam logic [2:0] O_BLOCK = 3'd1;
  localparam logic [2:0] T_BLOCK = 3'd2;
  localparam logic [2:0] S_BLOCK = 3'd3;
  localparam logic [2:0] Z_BLOCK = 3'd4;
  localparam logic [2:0] J_BLOCK = 3'd5;
  localparam logic [2:0] L_BLOCK = 3'd6;

  // Squares outside the playfield never collide and are never written.
  function automatic logic sq_in_range(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    return (col < COL_W'(COLS)) && (row < ROW_W'(ROWS));
  endfunction

endpackage

// File: rtl/collision_chk.sv
// Combinational hit test of four piece squares against the floor and the grid rows beneath them.
module collision_chk
  import tetris_pkg::*;
(
  input  logic [3:0][COL_W-1:0] sq_col_i,
  input  logic [3:0][ROW_W-1:0] sq_row_i,
  input  logic [3:0][COLS-1:0]  below_i,
  output logic                  hit_o
);

  always_comb begin
    hit_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (sq_in_range(sq_col_i[i], sq_row_i[i])) begin
        if (sq_row_i[i] == ROW_W'(ROWS - 1) || below_i[i][sq_col_i[i]]) begin
          hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/board_ctl.sv
// Playfield owner: occupancy grid, collision report, lock / line-clear sequencer and renderer read port.
module board_ctl
  import tetris_pkg::*;
(
  input  logic                 pclk,
  input  logic                 rst,
  input  logic [COL_W-1:0]     sq_1_col,
  input  logic [COL_W-1:0]     sq_2_col,
  input  logic [COL_W-1:0]     sq_3_col,
  input  logic [COL_W-1:0]     sq_4_col,
  input  logic [ROW_W-1:0]     sq_1_row,
  input  logic [ROW_W-1:0]     sq_2_row,
  input  logic [ROW_W-1:0]     sq_3_row,
  input  logic [ROW_W-1:0]     sq_4_row,
  input  logic                 lock_en,
  input  logic [ROW_W-1:0]     rd_row,
  output logic [COLS-1:0]      rd_data,
  output logic                 collision,
  output logic                 busy,
  output logic                 line_clr,
  output logic [LINES_W-1:0]   lines,
  output logic                 game_over
);

  logic [COLS-1:0]          grid_q [ROWS];
  board_state_e             state_q;
  logic [3:0][COL_W-1:0]    cap_col_q;
  logic [3:0][ROW_W-1:0]    cap_row_q;
  logic [ROW_W-1:0]         scan_r_q;
  logic [COLS-1:0]          rd_data_q;
  logic                     collision_q;
  logic                     busy_q;
  logic                     line_clr_q;
  logic [LINES_W-1:0]       lines_q;
  logic                     game_over_q;

  logic [3:0][COL_W-1:0]    sq_col;
  logic [3:0][ROW_W-1:0]    sq_row;
  logic [3:0][COLS-1:0]     below;
  logic                     collision_d;
  logic [COLS-1:0]          rd_data_d;

  assign sq_col = {sq_4_col, sq_3_col, sq_2_col, sq_1_col};
  assign sq_row = {sq_4_row, sq_3_row, sq_2_row, sq_1_row};

  // The floor row has nothing below it; the checker handles it explicitly.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_below
      assign below[gi] = (sq_row[gi] < ROW_W'(ROWS - 1)) ? grid_q[sq_row[gi] + ROW_W'(1)] : '0;
    end
  endgenerate

  collision_chk u_collision_chk (
    .sq_col_i (sq_col),
    .sq_row_i (sq_row),
    .below_i  (below),
    .hit_o    (collision_d)
  );

  assign rd_data_d = (rd_row < ROW_W'(ROWS)) ? grid_q[rd_row] : '0;

  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int k = 0; k < ROWS; k++) grid_q[k] <= '0;
      state_q     <= IDLE;
      cap_col_q   <= '0;
      cap_row_q   <= '0;
      scan_r_q    <= '0;
      rd_data_q   <= '0;
      collision_q <= 1'b0;
      busy_q      <= 1'b0;
      line_clr_q  <= 1'b0;
      lines_q     <= '0;
      game_over_q <= 1'b0;
    end else begin
      rd_data_q   <= rd_data_d;
      collision_q <= collision_d;
      line_clr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lock_en) begin
            cap_col_q <= sq_col;
            cap_row_q <= sq_row;
            busy_q    <= 1'b1;
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          for (int i = 0; i < 4; i++) begin
            if (sq_in_range(cap_col_q[i], cap_row_q[i])) begin
              grid_q[cap_row_q[i]][cap_col_q[i]] <= 1'b1;
            end
          end
          scan_r_q <= ROW_W'(ROWS - 1);
          state_q  <= SCAN;
        end
        SCAN: begin
          if (grid_q[scan_r_q] == '1) begin
            line_clr_q <= 1'b1;
            state_q    <= SHIFT;
          end else if (scan_r_q == '0) begin
            state_q <= DONE;
          end else begin
            scan_r_q <= scan_r_q - ROW_W'(1);
          end
        end
        SHIFT: begin
          // Rows above the cleared one drop by one; the scan pointer stays to rescan it.
          for (int k = 1; k < ROWS; k++) begin
            if (ROW_W'(k) <= scan_r_q) grid_q[k] <= grid_q[k-1];
          end
          grid_q[0] <= '0;
          lines_q   <= lines_q + LINES_W'(1);
          state_q   <= SCAN;
        end
        DONE: begin
          if (grid_q[0] != '0) game_over_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_data   = rd_data_q;
  assign collision = collision_q;
  assign busy      = busy_q;
  assign line_clr  = line_clr_q;
  assign lines     = lines_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_board_ctl.sv
// Directed self-checking bench for board_ctl: collision, lock, single/double clears, game over, reset.
module tb_board_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic [3:0]  sq_1_col, sq_2_col, sq_3_col, sq_4_col;
  logic [4:0]  sq_1_row, sq_2_row, sq_3_row, sq_4_row;
  logic        lock_en;
  logic [4:0]  rd_row;
  logic [9:0]  rd_data;
  logic        collision;
  logic        busy;
  logic        line_clr;
  logic [15:0] lines;
  logic        game_over;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int pulses;
  logic [9:0] row_val;

  always #5 pclk = ~pclk;

  board_ctl dut (
    .pclk      (pclk),
    .rst       (rst),
    .sq_1_col  (sq_1_col),
    .sq_2_col  (sq_2_col),
    .sq_3_col  (sq_3_col),
    .sq_4_col  (sq_4_col),
    .sq_1_row  (sq_1_row),
    .sq_2_row  (sq_2_row),
    .sq_3_row  (sq_3_row),
    .sq_4_row  (sq_4_row),
    .lock_en   (lock_en),
    .rd_row    (rd_row),
    .rd_data   (rd_data),
    .collision (collision),
    .busy      (busy),
    .line_clr  (line_clr),
    .lines     (lines),
    .game_over (game_over)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_sq(input logic [3:0] c1, input logic [4:0] r1, input logic [3:0] c2, input logic [4:0] r2,
                        input logic [3:0] c3, input logic [4:0] r3, input logic [3:0] c4, input logic [4:0] r4);
    sq_1_col = c1; sq_1_row = r1;
    sq_2_col = c2; sq_2_row = r2;
    sq_3_col = c3; sq_3_row = r3;
    sq_4_col = c4; sq_4_row = r4;
  endtask

  task automatic start_lock();
    lock_en = 1'b1;
    tick();
    lock_en = 1'b0;
  endtask

  // Counts busy cycles and line_clr pulses; an overrun is reported as a failed comparison.
  task automatic wait_done(output int cycles, output int clr);
    cycles = 0;
    clr = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (line_clr === 1'b1) clr++;
      tick();
    end
    if (cycles >= 200) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic lock_piece(input logic [3:0] c1, input logic [4:0] r1, input logic [3:0] c2, input logic [4:0] r2,
                            input logic [3:0] c3, input logic [4:0] r3, input logic [3:0] c4, input logic [4:0] r4);
    set_sq(c1, r1, c2, r2, c3, r3, c4, r4);
    start_lock();
    wait_done(cyc, pulses);
  endtask

  task automatic read_row(input logic [4:0] r, output logic [9:0] val);
    rd_row = r;
    tick();
    val = rd_data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lock_en = 1'b0;
    rd_row = 5'd0;
    set_sq(4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    tick();
    tick();
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_clr", 32'(line_clr), 32'd0);
    check("rst_lines", 32'(lines), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;

    // Floor hit and empty-grid miss.
    set_sq(4'd3, 5'd19, 4'd4, 5'd19, 4'd5, 5'd19, 4'd6, 5'd19);
    tick();
    check("floor_hit", 32'(collision), 32'd1);
    set_sq(4'd3, 5'd18, 4'd4, 5'd18, 4'd5, 5'd18, 4'd6, 5'd18);
    tick();
    check("row18_empty", 32'(collision), 32'd0);
    set_sq(4'd12, 5'd19, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    tick();
    check("offboard_ignored", 32'(collision), 32'd0);

    // Lock, no clear.
    lock_piece(4'd4, 5'd18, 4'd5, 5'd18, 4'd4, 5'd19, 4'd5, 5'd19);
    check("o_busy_cycles", 32'(cyc), 32'd22);
    check("o_clr_pulses", 32'(pulses), 32'd0);
    check("o_busy_low", 32'(busy), 32'd0);
    read_row(5'd19, row_val);
    check("o_row19", 32'(row_val), 32'h030);
    read_row(5'd18, row_val);
    check("o_row18", 32'(row_val), 32'h030);
    check("o_lines", 32'(lines), 32'd0);

    // Single clear.
    do_reset();
    lock_piece(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19);
    lock_piece(4'd4, 5'd19, 4'd5, 5'd19, 4'd8, 5'd19, 4'd9, 5'd19);
    read_row(5'd19, row_val);
    check("pre1_row19", 32'(row_val), 32'h33F);
    lock_piece(4'd6, 5'd18, 4'd7, 5'd18, 4'd6, 5'd19, 4'd7, 5'd19);
    check("c1_busy_cycles", 32'(cyc), 32'd24);
    check("c1_clr_pulses", 32'(pulses), 32'd1);
    check("c1_lines", 32'(lines), 32'd1);
    read_row(5'd19, row_val);
    check("c1_row19", 32'(row_val), 32'h0C0);
    read_row(5'd18, row_val);
    check("c1_row18", 32'(row_val), 32'h000);
    read_row(5'd0, row_val);
    check("c1_row0", 32'(row_val), 32'h000);

    // Double clear.
    do_reset();
    lock_piece(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19);
    lock_piece(4'd4, 5'd19, 4'd5, 5'd19, 4'd6, 5'd19, 4'd7, 5'd19);
    lock_piece(4'd8, 5'd19, 4'd0, 5'd18, 4'd1, 5'd18, 4'd2, 5'd18);
    lock_piece(4'd3, 5'd18, 4'd4, 5'd18, 4'd5, 5'd18, 4'd6, 5'd18);
    lock_piece(4'd7, 5'd18, 4'd8, 5'd18, 4'd15, 5'd0, 4'd15, 5'd0);
    read_row(5'd18, row_val);
    check("pre2_row18", 32'(row_val), 32'h1FF);
    lock_piece(4'd9, 5'd16, 4'd9, 5'd17, 4'd9, 5'd18, 4'd9, 5'd19);
    check("c2_busy_cycles", 32'(cyc), 32'd26);
    check("c2_clr_pulses", 32'(pulses), 32'd2);
    check("c2_lines", 32'(lines), 32'd2);
    read_row(5'd19, row_val);
    check("c2_row19", 32'(row_val), 32'h200);
    read_row(5'd18, row_val);
    check("c2_row18", 32'(row_val), 32'h200);
    read_row(5'd17, row_val);
    check("c2_row17", 32'(row_val), 32'h000);
    read_row(5'd0, row_val);
    check("c2_row0", 32'(row_val), 32'h000);

    // Collision against the stack.
    do_reset();
    check("rst_lines_cleared", 32'(lines), 32'd0);
    lock_piece(4'd5, 5'd10, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    set_sq(4'd5, 5'd9, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    tick();
    check("stack_hit", 32'(collision), 32'd1);
    set_sq(4'd4, 5'd9, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    tick();
    check("stack_miss", 32'(collision), 32'd0);

    // Game over; a lock_en during busy must be ignored.
    do_reset();
    check("go_before", 32'(game_over), 32'd0);
    set_sq(4'd0, 5'd0, 4'd1, 5'd0, 4'd2, 5'd0, 4'd3, 5'd0);
    start_lock();
    tick();
    tick();
    set_sq(4'd0, 5'd19, 4'd1, 5'd19, 4'd2, 5'd19, 4'd3, 5'd19);
    start_lock();
    wait_done(cyc, pulses);
    set_sq(4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0, 4'd15, 5'd0);
    tick();
    check("go_set", 32'(game_over), 32'd1);
    check("go_busy_idle", 32'(busy), 32'd0);
    read_row(5'd19, row_val);
    check("ignored_lock_row19", 32'(row_val), 32'h000);
    read_row(5'd0, row_val);
    check("go_row0", 32'(row_val), 32'h00F);
    read_row(5'd25, row_val);
    check("rd_out_of_range", 32'(row_val), 32'h000);

    do_reset();
    check("rst_game_over2", 32'(game_over), 32'd0);
    check("rst_lines2", 32'(lines), 32'd0);
    read_row(5'd0, row_val);
    check("rst_row0", 32'(row_val), 32'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
